// File: rtl/bch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bch_pkg
// Purpose : GF(2^13) constants, FSM state type and constant-multiplier helpers
//           shared by the BCH syndrome generator.
// Revision: 1.0 - initial release
// ============================================================================
package bch_pkg;

  localparam int GF_M = 13;
  // x^13 + x^4 + x^3 + x + 1
  localparam logic [GF_M:0] GF_POLY = 14'h201B;
  localparam int T    = 8;
  localparam int NSYN = 2 * T;
  // Upper bound on the constant exponent of a single multiplier
  localparam int MAX_POW = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } bch_state_e;

  function automatic logic [GF_M-1:0] gf_mul_alpha(input logic [GF_M-1:0] a);
    return {a[GF_M-2:0], 1'b0} ^ (a[GF_M-1] ? GF_POLY[GF_M-1:0] : {GF_M{1'b0}});
  endfunction

  // Called with a constant n, so it folds into a fixed XOR network
  function automatic logic [GF_M-1:0] gf_mul_alpha_pow(input logic [GF_M-1:0] a,
                                                       input int n);
    logic [GF_M-1:0] r;
    r = a;
    for (int k = 0; k < MAX_POW; k++) begin
      if (k < n) r = gf_mul_alpha(r);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/syn_horner_cell.sv
`default_nettype none
// ============================================================================
// Module  : syn_horner_cell
// Purpose : One Horner-rule syndrome accumulator S <= S*alpha^I ^ bit.
// Revision: 1.0 - initial release
// ============================================================================
module syn_horner_cell
  import bch_pkg::*;
#(
  parameter int I = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic            bit_i,
  output logic [GF_M-1:0] syn_o
);

  logic [GF_M-1:0] syn_q;
  logic [GF_M-1:0] syn_d;
  logic [GF_M-1:0] prod_w;

  // A clear folds into the first update so the first bit needs no extra cycle
  always_comb begin
    prod_w = gf_mul_alpha_pow(syn_q, I);
    syn_d  = syn_q;
    if (en_i) begin
      syn_d = (clr_i ? {GF_M{1'b0}} : prod_w) ^ {{(GF_M-1){1'b0}}, bit_i};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      syn_q <= '0;
    end else begin
      syn_q <= syn_d;
    end
  end

  assign syn_o = syn_q;

endmodule
`default_nettype wire

// File: rtl/bch_syndrome_gen.sv
`default_nettype none
// ============================================================================
// Module  : bch_syndrome_gen
// Purpose : Serial BCH syndrome generator over GF(2^13); accumulates S1..SNSYN
//           per received bit, then streams them out one word per cycle.
// Revision: 1.0 - initial release
// ============================================================================
module bch_syndrome_gen
  import bch_pkg::*;
#(
  parameter int N    = 8191,
  parameter int NSYN = bch_pkg::NSYN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            in_bit,
  input  logic            in_last,
  output logic            in_ready,
  output logic            start,
  output logic [GF_M-1:0] gsynd,
  output logic            syn_valid,
  output logic            syn_nz,
  output logic            len_err
);

  localparam int IDX_W = (NSYN > 1) ? $clog2(NSYN) : 1;
  localparam int CNT_W = GF_M + 1;

  bch_state_e       state_q, state_d;
  logic [GF_M-1:0]  cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [IDX_W-1:0] drain_q, drain_d;
  logic             len_err_q, len_err_d;

  logic             accept_w;
  logic             clr_w;
  logic             drain_end_w;
  logic [CNT_W-1:0] cnt_inc_w;
  logic             len_bad_w;
  logic             nz_w;
  logic [GF_M-1:0]  syn_w [NSYN];

  assign accept_w    = in_valid & in_ready;
  assign clr_w       = (state_q == ST_IDLE);
  assign drain_end_w = (drain_q == IDX_W'(NSYN - 1));

  generate
    for (genvar g = 0; g < NSYN; g++) begin : g_cell
      syn_horner_cell #(
        .I (g + 1)
      ) u_cell (
        .clk   (clk),
        .reset (reset),
        .clr_i (clr_w),
        .en_i  (accept_w),
        .bit_i (in_bit),
        .syn_o (syn_w[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_w) state_d = in_last ? ST_DRAIN : ST_ACCUM;
      end
      ST_ACCUM: begin
        if (accept_w && in_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_end_w) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    syn_valid = 1'b0;
    start     = 1'b0;
    case (state_q)
      ST_IDLE, ST_ACCUM: in_ready = 1'b1;
      ST_DRAIN: begin
        syn_valid = 1'b1;
        start     = (drain_q == '0);
      end
      default: ;
    endcase
  end

  // The count is one wider than the field so lengths beyond 2^13-1 stay wrong
  always_comb begin
    cnt_inc_w = (state_q == ST_IDLE) ? CNT_W'(1) : ({1'b0, cnt_q} + CNT_W'(1));
    len_bad_w = ((state_q != ST_IDLE) && ovf_q) || (cnt_inc_w != CNT_W'(N));
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    len_err_d = len_err_q;
    drain_d   = drain_q;
    if (accept_w) begin
      cnt_d = cnt_inc_w[GF_M-1:0];
      ovf_d = ((state_q != ST_IDLE) && ovf_q) || cnt_inc_w[GF_M];
      if (in_last) len_err_d = len_bad_w;
    end
    if (state_q == ST_DRAIN) begin
      drain_d = drain_end_w ? '0 : drain_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      drain_q   <= '0;
      len_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      drain_q   <= drain_d;
      len_err_q <= len_err_d;
    end
  end

  always_comb begin
    gsynd = '0;
    nz_w  = 1'b0;
    for (int g = 0; g < NSYN; g++) begin
      nz_w = nz_w | (syn_w[g] != '0);
    end
    if (syn_valid) gsynd = syn_w[drain_q];
  end

  assign syn_nz  = syn_valid & nz_w;
  assign len_err = syn_valid & len_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bch_syndrome_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_bch_syndrome_gen
// Purpose : Directed/random bench for bch_syndrome_gen against a power-sum
//           syndrome model built from an antilog table.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bch_syndrome_gen;

  localparam int N    = 8191;
  localparam int NSYN = 16;
  localparam int Q    = 8191;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        start;
  logic [12:0] gsynd;
  logic        syn_valid;
  logic        syn_nz;
  logic        len_err;

  int checks = 0;
  int failures = 0;

  bit          cw [N];
  logic [12:0] alog [Q];
  logic [12:0] obs_syn [NSYN];

  bch_syndrome_gen #(.N(N), .NSYN(NSYN)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .start     (start),
    .gsynd     (gsynd),
    .syn_valid (syn_valid),
    .syn_nz    (syn_nz),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // S_i = sum over set positions p of alpha^(i*p)
  function automatic logic [12:0] model_syn(input int i, input int len);
    logic [12:0] acc;
    acc = '0;
    for (int p = 0; p < len; p++) begin
      if (cw[p]) acc ^= alog[(i * p) % Q];
    end
    return acc;
  endfunction

  task automatic clear_cw();
    for (int p = 0; p < N; p++) cw[p] = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  in_ready,  1);
    check({tag, "_start"},     start,     0);
    check({tag, "_syn_valid"}, syn_valid, 0);
    check({tag, "_gsynd"},     gsynd,     0);
    check({tag, "_syn_nz"},    syn_nz,    0);
    check({tag, "_len_err"},   len_err,   0);
  endtask

  // Drives r(len-1)..r(0) starting at a falling edge; random idle gaps 1/gapmod
  task automatic send(input int len, input int gapmod);
    int wait_cnt;
    for (int p = len - 1; p >= 0; p--) begin
      if (gapmod != 0) begin
        while ($urandom_range(gapmod - 1) == 0) begin
          in_valid = 1'b0;
          @(negedge clk);
        end
      end
      wait_cnt = 0;
      while (!in_ready && wait_cnt < 40) begin
        @(negedge clk);
        wait_cnt++;
      end
      if (!in_ready) begin
        check("ready_timeout", in_ready, 1);
        return;
      end
      in_valid = 1'b1;
      in_bit   = cw[p];
      in_last  = (p == 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input string tag, input int len, input bit exp_le,
                       input bit hold, input int abort_at);
    logic [12:0] se [NSYN];
    bit nz;
    nz = 1'b0;
    for (int i = 0; i < NSYN; i++) begin
      se[i] = model_syn(i + 1, len);
      nz |= (se[i] != 0);
    end
    in_valid = hold;
    in_bit   = hold;
    for (int w = 0; w < NSYN; w++) begin
      obs_syn[w] = gsynd;
      check($sformatf("%s_w%0d_valid", tag, w), syn_valid, 1);
      check($sformatf("%s_w%0d_gsynd", tag, w), gsynd, se[w]);
      check($sformatf("%s_w%0d_start", tag, w), start, (w == 0));
      check($sformatf("%s_w%0d_ready", tag, w), in_ready, 0);
      check($sformatf("%s_w%0d_nz", tag, w), syn_nz, nz);
      check($sformatf("%s_w%0d_lenerr", tag, w), len_err, exp_le);
      if (abort_at == w + 1) begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        @(negedge clk);
        check_reset_outputs({tag, "_abort"});
        reset = 1'b0;
        return;
      end
      @(negedge clk);
    end
    check({tag, "_after_valid"}, syn_valid, 0);
    check({tag, "_after_gsynd"}, gsynd, 0);
    check({tag, "_after_ready"}, in_ready, 1);
    check({tag, "_after_start"}, start, 0);
  endtask

  initial begin
    int x;
    int j;
    int k;
    x = 1;
    for (int e = 0; e < Q; e++) begin
      alog[e] = x[12:0];
      x = x << 1;
      if (x >= 8192) x ^= 32'h201B;
    end

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle");

    clear_cw();
    send(N, 0);
    drain("zero", N, 0, 0, 0);

    cw[0] = 1'b1;
    send(N, 0);
    drain("r0", N, 0, 0, 0);

    clear_cw();
    cw[1] = 1'b1;
    send(N, 0);
    drain("r1", N, 0, 0, 0);
    check("r1_S1_const", obs_syn[0], 13'h0002);
    check("r1_S2_const", obs_syn[1], 13'h0004);
    check("r1_S3_const", obs_syn[2], 13'h0008);

    clear_cw();
    cw[N-1] = 1'b1;
    send(N, 0);
    drain("rtop", N, 0, 0, 0);
    check("rtop_S1_const", obs_syn[0], 13'h100D);

    clear_cw();
    for (int p = 0; p < 100; p++) cw[p] = bit'($urandom_range(1));
    send(100, 0);
    drain("short100", 100, 1, 1, 0);

    clear_cw();
    for (int p = 0; p < 5; p++) cw[p] = bit'($urandom_range(1));
    cw[4] = 1'b1;
    send(5, 0);
    drain("short5_abort", 5, 1, 0, 5);

    clear_cw();
    cw[0] = 1'b1;
    send(N, 0);
    drain("r0_after_reset", N, 0, 0, 0);

    clear_cw();
    j = $urandom_range(N - 1);
    cw[j] = 1'b1;
    send(N, 16);
    drain($sformatf("single_j%0d", j), N, 0, 0, 0);

    clear_cw();
    j = $urandom_range(N - 1);
    k = $urandom_range(N - 1);
    if (k == j) k = (j + 1) % N;
    cw[j] = 1'b1;
    cw[k] = 1'b1;
    send(N, 16);
    drain($sformatf("double_j%0d_k%0d", j, k), N, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
